// File: rtl/key_pkg.sv
// Shared definitions for the key scheduler: FSM states, LFSR taps and the
// substitute used when a zero seed is loaded (zero would lock the LFSR).
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    // Feedback taps at bit positions 7, 5, 4 and 3 (maximal length, period 255).
    localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;
    localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

endpackage

// File: rtl/key_lfsr.sv
// Combinational next-key function: one left shift of the 8-bit Fibonacci LFSR.
module key_lfsr
    import key_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = {din[6:0], ^(din & LFSR_TAPS)};

endmodule

// File: rtl/key_scheduler.sv
// Issues ROUNDS LFSR-derived keys per seed over a valid/ready handshake, then
// raises rekey until a new seed is loaded.
module key_scheduler
    import key_pkg::*;
#(
    parameter int ROUNDS = 16,
    parameter int WIDTH  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       seed,
    input  logic             seed_load,
    input  logic             key_ready,
    output logic [WIDTH-1:0] key,
    output logic             key_valid,
    output logic [7:0]       round,
    output logic             rekey
);

    localparam logic [7:0] ROUND_LIMIT = 8'(ROUNDS);

    state_t     state_reg, state_next;
    logic [7:0] key_reg, key_next;
    logic [7:0] round_reg, round_next;
    logic       key_valid_reg, key_valid_next;
    logic       rekey_reg, rekey_next;
    logic [7:0] lfsr_out;
    logic [7:0] round_inc;

    key_lfsr u_lfsr (
        .din  (key_reg),
        .dout (lfsr_out)
    );

    assign round_inc = round_reg + 8'd1;

    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        round_next = round_reg;
        // A seed load wins over any handshake at the same edge.
        if (seed_load) begin
            key_next   = (seed == 8'h00) ? ZERO_SEED_SUB : seed;
            round_next = 8'd0;
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN: begin
                    if (key_ready) begin
                        key_next   = lfsr_out;
                        round_next = round_inc;
                        if (round_inc == ROUND_LIMIT) begin
                            state_next = EXPIRED;
                        end
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end
        key_valid_next = (state_next == RUN);
        rekey_next     = (state_next == EXPIRED);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            key_reg       <= 8'h00;
            round_reg     <= 8'd0;
            key_valid_reg <= 1'b0;
            rekey_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            key_reg       <= key_next;
            round_reg     <= round_next;
            key_valid_reg <= key_valid_next;
            rekey_reg     <= rekey_next;
        end
    end

    assign key       = key_reg;
    assign key_valid = key_valid_reg;
    assign round     = round_reg;
    assign rekey     = rekey_reg;

endmodule

// File: tb/tb_key_scheduler.sv
// Bench for key_scheduler: directed vector table, hand-written corner sequences
// and random traffic checked against a sequence-level model (ROUNDS=16 and 4).
module tb_key_scheduler;

    logic       clock;
    logic       reset;
    logic [7:0] seed;
    logic       seed_load;
    logic       key_ready;

    logic [7:0] k16, r16, k4, r4;
    logic       v16, rk16, v4, rk4;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    key_scheduler #(.ROUNDS(16), .WIDTH(8)) dut16 (
        .clock(clock), .reset(reset), .seed(seed), .seed_load(seed_load),
        .key_ready(key_ready), .key(k16), .key_valid(v16), .round(r16), .rekey(rk16)
    );

    key_scheduler #(.ROUNDS(4), .WIDTH(8)) dut4 (
        .clock(clock), .reset(reset), .seed(seed), .seed_load(seed_load),
        .key_ready(key_ready), .key(k4), .key_valid(v4), .round(r4), .rekey(rk4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a sequence is "live" after a load, counts accepted keys,
    // and is spent once the count reaches the limit.
    int         lim [2] = '{16, 4};
    bit         m_live [2];
    bit         m_spent [2];
    logic [7:0] m_key [2];
    int         m_cnt [2];

    function automatic logic [7:0] next_key(input logic [7:0] k);
        return {k[6:0], k[7] ^ k[5] ^ k[4] ^ k[3]};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_live[i] = 0; m_spent[i] = 0; m_key[i] = 8'h00; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_live[i] = 0; m_spent[i] = 0; m_key[i] = 8'h00; m_cnt[i] = 0;
            end else if (seed_load) begin
                m_key[i] = (seed == 8'h00) ? 8'h01 : seed;
                m_cnt[i] = 0; m_live[i] = 1; m_spent[i] = 0;
            end else if (m_live[i] && key_ready) begin
                m_key[i] = next_key(m_key[i]);
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == lim[i]) begin
                    m_live[i] = 0; m_spent[i] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_model();
        chk("r16 key",   k16,        m_key[0]);
        chk("r16 valid", {7'd0, v16},  {7'd0, m_live[0]});
        chk("r16 round", r16,        8'(m_cnt[0]));
        chk("r16 rekey", {7'd0, rk16}, {7'd0, m_spent[0]});
        chk("r4 key",    k4,         m_key[1]);
        chk("r4 valid",  {7'd0, v4},   {7'd0, m_live[1]});
        chk("r4 round",  r4,         8'(m_cnt[1]));
        chk("r4 rekey",  {7'd0, rk4},  {7'd0, m_spent[1]});
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        compare_model();
        $display("cyc %0d rst_n=%b ld=%b seed=%02h rdy=%b | r16 key=%02h v=%b rnd=%0d rk=%b | r4 key=%02h v=%b rnd=%0d rk=%b",
                 cyc, reset, seed_load, seed, key_ready, k16, v16, r16, rk16, k4, v4, r4, rk4);
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_clear();
        compare_model();
        chk("async key",   k16, 8'h00);
        chk("async valid", {7'd0, v16}, 8'h00);
        chk("async round", r16, 8'h00);
    endtask

    typedef struct {
        logic       ld;
        logic [7:0] sd;
        logic       rdy;
        logic [7:0] ek;
        logic       ev;
        logic [7:0] er;
        logic       erk;
    } vec_t;

    vec_t vecs [12];

    logic [7:0] exp4 [4];

    initial begin
        reset = 1'b0; seed = 8'h00; seed_load = 1'b0; key_ready = 1'b0;
        model_clear();
        #2;
        chk("reset key",   k16, 8'h00);
        chk("reset valid", {7'd0, v16}, 8'h00);
        chk("reset round", r16, 8'h00);
        chk("reset rekey", {7'd0, rk16}, 8'h00);
        compare_model();

        @(negedge clock);
        reset = 1'b1;
        key_ready = 1'b1;
        step();
        chk("idle after release", {7'd0, v16}, 8'h00);

        // ROUNDS=16 instance directed vectors: load, handshakes, stall, collision, zero seed.
        vecs[0]  = '{1'b1, 8'h93, 1'b0, 8'h93, 1'b1, 8'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 8'h26, 1'b1, 8'd1, 1'b0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 8'h4D, 1'b1, 8'd2, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h4D, 1'b1, 8'd2, 1'b0};
        vecs[4]  = '{1'b1, 8'hAC, 1'b1, 8'hAC, 1'b1, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 8'h01, 1'b1, 8'd0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'd0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'd0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'd0, 1'b0};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'd0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 8'd0, 1'b0};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'd1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            seed_load = vecs[i].ld; seed = vecs[i].sd; key_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d key", i),   k16, vecs[i].ek);
            chk($sformatf("vec%0d valid", i), {7'd0, v16}, {7'd0, vecs[i].ev});
            chk($sformatf("vec%0d round", i), r16, vecs[i].er);
            chk($sformatf("vec%0d rekey", i), {7'd0, rk16}, {7'd0, vecs[i].erk});
        end

        // ROUNDS=4: continuous ready exhausts the sequence and freezes it.
        exp4 = '{8'h26, 8'h4D, 8'h9B, 8'h37};
        seed_load = 1'b1; seed = 8'h93; key_ready = 1'b0;
        step();
        chk("r4 load key", k4, 8'h93);
        seed_load = 1'b0; key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("r4 hs%0d key", i), k4, exp4[i]);
            chk($sformatf("r4 hs%0d round", i), r4, 8'(i + 1));
        end
        chk("r4 expired valid", {7'd0, v4}, 8'h00);
        chk("r4 expired rekey", {7'd0, rk4}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("r4 frozen key", k4, 8'h37);
            chk("r4 frozen round", r4, 8'd4);
        end

        // Asynchronous reset in the middle of a running sequence.
        seed_load = 1'b1; seed = 8'hAC; key_ready = 1'b0;
        step();
        seed_load = 1'b0; key_ready = 1'b1;
        step();
        #2;
        async_reset();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post reset valid", {7'd0, v16}, 8'h00);
        end
        seed_load = 1'b1; seed = 8'h5A;
        step();
        chk("reload key", k16, 8'h5A);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            seed_load = ($urandom_range(0, 7) == 0);
            seed      = 8'($urandom);
            if ($urandom_range(0, 9) == 0) seed = 8'h00;
            key_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 79) == 0) begin
                #2;
                async_reset();
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 SHALL have parameter ROUNDS, default 16: number of keys issued per seed (legal range 1..255).
REQ-002 SHALL have parameter WIDTH, default 8: key width; only 8 is supported, and the LFSR taps are fixed for 8.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port seed, input, 8 bits: seed value sampled when seed_load=1.
REQ-006 SHALL have port seed_load, input, 1 bit: load seed and start a new key sequence.
REQ-007 SHALL have port key_ready, input, 1 bit: downstream encrypt stage accepts the current key.
REQ-008 SHALL have port key, output, 8 bits: current key, which drives the encrypt stage key input.
REQ-009 SHALL have port key_valid, output, 1 bit: key holds a usable value.
REQ-010 SHALL have port round, output, 8 bits: count of keys accepted since the last seed_load.
REQ-011 SHALL have port rekey, output, 1 bit: sequence exhausted; a new seed is required.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and EXPIRED; all outputs are registered.
REQ-013 SHALL, on seed_load=1 in any state, load key <= (seed==8'h00 ? 8'h01 : seed), clear round to 0 and enter RUN at the next edge.
REQ-014 SHALL ensure key/key_valid are visible in the cycle following the seed_load edge (latency 1).
REQ-015 SHALL drive key_valid=1 only in RUN, and rekey=1 only in EXPIRED.
REQ-016 SHALL treat a handshake as key_valid & key_ready at a rising edge; key and round change only on a handshake or on seed_load.
REQ-017 SHALL, on a handshake, advance the key: key <= {key[6:0], key[7]^key[5]^key[4]^key[3]} (maximal-length period of 255, never zero).
REQ-018 SHALL, on a handshake, increment round; when the incremented round equals ROUNDS, enter EXPIRED with key_valid=0 and rekey=1.
REQ-019 SHALL hold key, round and state while key_valid=1 and key_ready=0, so key stays stable until accepted.
REQ-020 SHALL ignore key_ready in IDLE and EXPIRED.
REQ-021 SHALL give seed_load priority when seed_load and a handshake occur at the same edge: the seed loads, round=0 and no advance occurs.
REQ-022 SHALL keep round a saturating 8-bit value, never exceeding ROUNDS.
REQ-023 SHALL hold key at its last value in EXPIRED; round holds ROUNDS.

Reset
REQ-024 SHALL, while reset=0, immediately force state=IDLE, key=8'h00, key_valid=0, round=0 and rekey=0, independent of clock.
REQ-025 SHALL, on reset assertion mid-sequence, discard the sequence; after release the block stays in IDLE until seed_load.
REQ-026 SHALL take no action on the first edge after reset release unless seed_load=1.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/EXPIRED), the LFSR tap constant (positions 7,5,4,3) and the zero-seed substitute 8'h01 in the shared package key_pkg.
REQ-028 SHALL implement the next-key function as one combinational sub-module, key_lfsr (8-bit in, 8-bit out).
REQ-029 SHALL keep the FSM, round counter and output registers in key_scheduler itself.

Verification
REQ-030 SHALL verify: seed=8'h93 with seed_load pulse -> next cycle key=8'h93, key_valid=1, round=0.
REQ-031 SHALL verify: from key=8'h93, two handshakes -> key=8'h26 then 8'h4D, round=1 then 2.
REQ-032 SHALL verify: seed=8'h00 loaded -> key=8'h01; key_ready held 0 for 5 cycles -> key stays 8'h01 and round stays 0.
REQ-033 SHALL verify: ROUNDS=4 with key_ready=1 continuously -> four keys issued, then key_valid=0, rekey=1, round=4 and key frozen.
REQ-034 SHALL verify: seed_load=1 with seed=8'hAC at the same edge as a handshake -> key=8'hAC and round=0.
REQ-035 SHALL verify: reset=0 asserted mid-RUN between clock edges -> outputs clear immediately; after release key_valid stays 0 until seed_load.
